// File: rtl/mega_ram_reader_if.sv
// RAM read port plus output word stream of mega_ram_reader, seen from the reader (master)
// and from the RAM/consumer side (slave).
interface mega_ram_reader_if #(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH = 8
);
  logic [ADDR_BUS_WIDTH-1:0] ram_a;
  logic                      ram_re;
  logic [DATA_BUS_WIDTH-1:0] ram_d;
  logic [DATA_BUS_WIDTH-1:0] s_data;
  logic                      s_valid;
  logic                      s_ready;

  modport master (
    output ram_a, ram_re, s_data, s_valid,
    input  ram_d, s_ready
  );

  modport slave (
    input  ram_a, ram_re, s_data, s_valid,
    output ram_d, s_ready
  );
endinterface

// File: rtl/mega_ram_reader.sv
// Streams len words from RAM starting at base_addr; first s_valid 3 cycles after start, 1 word/3 cycles.
// s_ready low parks the FSM in OUT with s_data held and the RAM idle; nothing is dropped.
module mega_ram_reader #(
  parameter int ADDR_BUS_WIDTH = 13,
  parameter int DATA_BUS_WIDTH = 8,
  parameter int LEN_WIDTH      = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [ADDR_BUS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]      len,
  output logic                      busy,
  output logic                      done,
  mega_ram_reader_if.master         bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, OUT, FIN} state_t;

  state_t                    state;
  logic [ADDR_BUS_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]      remaining;
  logic [DATA_BUS_WIDTH-1:0] s_data_q;
  logic                      s_valid_q;
  logic                      ram_re_q;

  // The address counter only moves when entering ISSUE, so it doubles as the held RAM address.
  assign bus.ram_a   = addr;
  assign bus.ram_re  = ram_re_q;
  assign bus.s_data  = s_data_q;
  assign bus.s_valid = s_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      s_data_q  <= '0;
      s_valid_q <= 1'b0;
      ram_re_q  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        busy      <= 1'b0;
        s_valid_q <= 1'b0;
        ram_re_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy <= 1'b1;
              if (len != '0) begin
                addr      <= base_addr;
                remaining <= len;
                ram_re_q  <= 1'b1;
                state     <= ISSUE;
              end else begin
                done  <= 1'b1;
                state <= FIN;
              end
            end
          end
          ISSUE: state <= CAPTURE;
          CAPTURE: begin
            s_data_q  <= bus.ram_d;
            ram_re_q  <= 1'b0;
            s_valid_q <= 1'b1;
            state     <= OUT;
          end
          OUT: begin
            if (bus.s_ready) begin
              s_valid_q <= 1'b0;
              if (remaining != LEN_WIDTH'(1)) begin
                remaining <= remaining - LEN_WIDTH'(1);
                addr      <= addr + ADDR_BUS_WIDTH'(1);
                ram_re_q  <= 1'b1;
                state     <= ISSUE;
              end else begin
                done  <= 1'b1;
                state <= FIN;
              end
            end
          end
          FIN: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy      <= 1'b0;
            s_valid_q <= 1'b0;
            ram_re_q  <= 1'b0;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mega_ram_reader.sv
// Directed bench for mega_ram_reader: synchronous RAM model, per-cycle stream monitor, scenario tasks.
module tb_mega_ram_reader;
  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [12:0] base_addr;
  logic [13:0] len;
  logic        busy, done;
  logic [7:0]  mem [0:8191];

  int checks = 0;
  int failures = 0;

  mega_ram_reader_if #(.ADDR_BUS_WIDTH(13), .DATA_BUS_WIDTH(8)) bus ();

  mega_ram_reader #(.ADDR_BUS_WIDTH(13), .DATA_BUS_WIDTH(8), .LEN_WIDTH(14)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .len(len), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data one cycle after the address, zero when not enabled.
  always @(posedge clk) bus.ram_d <= bus.ram_re ? mem[bus.ram_a] : 8'h00;

  // Stream monitor, cycle 0 is the cycle in which start is driven.
  logic        mon_en = 1'b0;
  int          mon_cyc, first_vld, done_cnt, done_cyc, re_cnt, vld_cnt;
  logic [7:0]  words [$];
  logic [12:0] addrs [$];
  logic        re_in_out, unstable, busy_after_done;
  logic        prev_vld, prev_hs, prev_done;
  logic [7:0]  prev_dat;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.s_valid && bus.s_ready) words.push_back(bus.s_data);
      if (bus.ram_re) begin addrs.push_back(bus.ram_a); re_cnt++; end
      if (bus.s_valid) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = mon_cyc;
      end
      if (bus.ram_re && bus.s_valid) re_in_out = 1'b1;
      if (prev_vld && !prev_hs && bus.s_valid && bus.s_data !== prev_dat) unstable = 1'b1;
      if (prev_done) busy_after_done = busy;
      if (done) begin done_cnt++; done_cyc = mon_cyc; end
      prev_vld  = bus.s_valid;
      prev_hs   = bus.s_valid && bus.s_ready;
      prev_dat  = bus.s_data;
      prev_done = done;
      mon_cyc++;
    end
  end

  task automatic mon_clear();
    words.delete(); addrs.delete();
    mon_cyc = 0; first_vld = -1; done_cnt = 0; done_cyc = -1; re_cnt = 0; vld_cnt = 0;
    re_in_out = 1'b0; unstable = 1'b0; busy_after_done = 1'b1;
    prev_vld = 1'b0; prev_hs = 1'b0; prev_done = 1'b0; prev_dat = 8'h00;
    mon_en = 1'b1;
  endtask

  function automatic logic [7:0] wd(int i);
    return (i < words.size()) ? words[i] : 8'hxx;
  endfunction

  function automatic logic [12:0] ad(int i);
    return (i < addrs.size()) ? addrs[i] : 13'hxxxx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    tick(); tick();
    start = 1'b0; abort = 1'b0;
    checks++; if ({busy, done, bus.s_valid, bus.ram_re} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, bus.s_valid, bus.ram_re}); end
    checks++; if (bus.ram_a !== 13'h0000 || bus.s_data !== 8'h00) begin
      failures++; $display("FAIL reset_data got a=%h d=%h exp a=0000 d=00", bus.ram_a, bus.s_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_read();
    mon_clear();
    base_addr = 13'h0010; len = 14'd3; start = 1'b1; bus.s_ready = 1'b1;
    tick(); start = 1'b0;
    repeat (13) tick();
    mon_en = 1'b0;
    checks++; if (words.size() != 3 || {wd(0), wd(1), wd(2)} !== 24'hA1B2C3) begin
      failures++; $display("FAIL basic_words got n=%0d %h%h%h exp n=3 A1B2C3", words.size(), wd(0), wd(1), wd(2)); end
    checks++; if (first_vld != 3) begin
      failures++; $display("FAIL basic_latency got=%0d exp=3", first_vld); end
    checks++; if (done_cnt != 1 || done_cyc != 10) begin
      failures++; $display("FAIL basic_done got cnt=%0d cyc=%0d exp cnt=1 cyc=10", done_cnt, done_cyc); end
    checks++; if (busy_after_done !== 1'b0) begin
      failures++; $display("FAIL basic_busy_after_done got=%b exp=0", busy_after_done); end
    checks++; if (addrs.size() != 6 || ad(0) !== 13'h0010 || ad(2) !== 13'h0011 || ad(5) !== 13'h0012) begin
      failures++; $display("FAIL basic_addrs got n=%0d %h %h %h exp n=6 0010 0011 0012", addrs.size(), ad(0), ad(2), ad(5)); end
  endtask

  task automatic test_backpressure();
    mon_clear();
    base_addr = 13'h0010; len = 14'd3; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      bus.s_ready = !(c >= 6 && c < 11);
      tick();
      start = 1'b0;
    end
    mon_en = 1'b0; bus.s_ready = 1'b1;
    checks++; if (words.size() != 3 || {wd(0), wd(1), wd(2)} !== 24'hA1B2C3) begin
      failures++; $display("FAIL bp_words got n=%0d %h%h%h exp n=3 A1B2C3", words.size(), wd(0), wd(1), wd(2)); end
    checks++; if (unstable !== 1'b0 || re_in_out !== 1'b0) begin
      failures++; $display("FAIL bp_stall got unstable=%b re_in_out=%b exp 0 0", unstable, re_in_out); end
    checks++; if (vld_cnt != 8) begin
      failures++; $display("FAIL bp_valid_cycles got=%0d exp=8", vld_cnt); end
    checks++; if (done_cnt != 1 || done_cyc != 15) begin
      failures++; $display("FAIL bp_done got cnt=%0d cyc=%0d exp cnt=1 cyc=15", done_cnt, done_cyc); end
  endtask

  task automatic test_wrap();
    mon_clear();
    base_addr = 13'h1FFF; len = 14'd2; start = 1'b1; bus.s_ready = 1'b1;
    tick(); start = 1'b0;
    repeat (9) tick();
    mon_en = 1'b0;
    checks++; if (addrs.size() != 4 || ad(0) !== 13'h1FFF || ad(2) !== 13'h0000) begin
      failures++; $display("FAIL wrap_addrs got n=%0d %h %h exp n=4 1fff 0000", addrs.size(), ad(0), ad(2)); end
    checks++; if (words.size() != 2 || {wd(0), wd(1)} !== 16'h5A6B) begin
      failures++; $display("FAIL wrap_words got n=%0d %h%h exp n=2 5A6B", words.size(), wd(0), wd(1)); end
    checks++; if (done_cnt != 1 || done_cyc != 7) begin
      failures++; $display("FAIL wrap_done got cnt=%0d cyc=%0d exp cnt=1 cyc=7", done_cnt, done_cyc); end
  endtask

  task automatic test_zero_len();
    mon_clear();
    base_addr = 13'h0040; len = 14'd0; start = 1'b1; bus.s_ready = 1'b1;
    tick(); start = 1'b0;
    repeat (5) tick();
    mon_en = 1'b0;
    checks++; if (done_cnt != 1 || done_cyc != 1) begin
      failures++; $display("FAIL zero_done got cnt=%0d cyc=%0d exp cnt=1 cyc=1", done_cnt, done_cyc); end
    checks++; if (re_cnt != 0 || vld_cnt != 0) begin
      failures++; $display("FAIL zero_activity got re=%0d vld=%0d exp 0 0", re_cnt, vld_cnt); end
    checks++; if (busy_after_done !== 1'b0) begin
      failures++; $display("FAIL zero_busy_after_done got=%b exp=0", busy_after_done); end
  endtask

  task automatic test_abort_restart();
    mon_clear();
    base_addr = 13'h0010; len = 14'd4; start = 1'b1; bus.s_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      abort = (c == 5);
      tick();
      start = 1'b0;
    end
    abort = 1'b0;
    checks++; if ({busy, bus.s_valid, bus.ram_re} !== 3'b000 || words.size() != 1) begin
      failures++; $display("FAIL abort_idle got busy/vld/re=%b words=%0d exp 000 words=1", {busy, bus.s_valid, bus.ram_re}, words.size()); end
    repeat (4) tick();
    checks++; if (done_cnt != 0) begin
      failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    mon_clear();
    base_addr = 13'h0020; len = 14'd1; start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    repeat (7) tick();
    mon_en = 1'b0;
    checks++; if (words.size() != 1 || wd(0) !== 8'h3C) begin
      failures++; $display("FAIL restart_words got n=%0d %h exp n=1 3C", words.size(), wd(0)); end
    checks++; if (done_cnt != 1 || done_cyc != 4) begin
      failures++; $display("FAIL restart_done got cnt=%0d cyc=%0d exp cnt=1 cyc=4", done_cnt, done_cyc); end
  endtask

  task automatic test_reset_mid();
    mon_clear();
    base_addr = 13'h0010; len = 14'd3; start = 1'b1; bus.s_ready = 1'b0;
    tick(); start = 1'b0;
    tick(); tick();
    checks++; if (bus.s_valid !== 1'b1 || bus.s_data !== 8'hA1) begin
      failures++; $display("FAIL mid_out got vld=%b d=%h exp vld=1 d=A1", bus.s_valid, bus.s_data); end
    base_addr = 13'h0020; len = 14'd1; start = 1'b1;
    tick(); start = 1'b0;
    checks++; if (busy !== 1'b1 || bus.s_valid !== 1'b1 || bus.s_data !== 8'hA1 || bus.ram_a !== 13'h0010) begin
      failures++; $display("FAIL busy_start_ignored got busy=%b vld=%b d=%h a=%h exp 1 1 A1 0010", busy, bus.s_valid, bus.s_data, bus.ram_a); end
    rst = 1'b1; start = 1'b1;
    tick(); rst = 1'b0; start = 1'b0;
    checks++; if ({busy, done, bus.s_valid, bus.ram_re} !== 4'b0000 || bus.ram_a !== 13'h0000 || bus.s_data !== 8'h00) begin
      failures++; $display("FAIL mid_reset got ctrl=%b a=%h d=%h exp 0000 0000 00", {busy, done, bus.s_valid, bus.ram_re}, bus.ram_a, bus.s_data); end
    bus.s_ready = 1'b1;
    repeat (6) tick();
    mon_en = 1'b0;
    checks++; if (done_cnt != 0 || vld_cnt != 2 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_after_reset got done=%0d vld=%0d busy=%b exp 0 2 0", done_cnt, vld_cnt, busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; len = '0; bus.s_ready = 1'b0;
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h55;
    mem[13'h0010] = 8'hA1; mem[13'h0011] = 8'hB2; mem[13'h0012] = 8'hC3;
    mem[13'h1FFF] = 8'h5A; mem[13'h0000] = 8'h6B; mem[13'h0020] = 8'h3C;
    test_reset();
    test_basic_read();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_abort_restart();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/mega_ram_reader.md
MEGA_RAM_READER -- requirements
Module: mega_ram_reader

Interface
REQ-001 Parameter ADDR_BUS_WIDTH, default 13, RAM address width in bits.
REQ-002 Parameter DATA_BUS_WIDTH, default 8, RAM data width in bits.
REQ-003 Parameter LEN_WIDTH, default 14, width of the transfer length field.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  single-cycle request to begin a transfer; sampled only in IDLE.
REQ-007 Port abort  input  1  terminates any transfer in progress.
REQ-008 Port base_addr  input  ADDR_BUS_WIDTH  first RAM address, captured with start.
REQ-009 Port len  input  LEN_WIDTH  number of words to read, captured with start.
REQ-010 Port busy  output  1  high in every state except IDLE.
REQ-011 Port done  output  1  one-cycle pulse on normal completion.
REQ-012 Port ram_a  output  ADDR_BUS_WIDTH  address to the RAM.
REQ-013 Port ram_re  output  1  RAM read enable; RAM output reads zero when low.
REQ-014 Port ram_d  input  DATA_BUS_WIDTH  RAM read data, valid one cycle after the address is presented, provided ram_re is still high.
REQ-015 Port s_data  output  DATA_BUS_WIDTH  streamed word.
REQ-016 Port s_valid  output  1  s_data holds a word.
REQ-017 Port s_ready  input  1  consumer accepts the word when s_valid and s_ready are both high at a rising edge.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, CAPTURE, OUT and FIN.
REQ-019 In IDLE with start=1 and len!=0, the block SHALL latch base_addr into the address counter and len into the remaining counter, then enter ISSUE.
REQ-020 In IDLE with start=1 and len=0, the block SHALL enter FIN without any RAM access.
REQ-021 In ISSUE, ram_a SHALL equal the address counter and ram_re SHALL be 1; the next state SHALL be CAPTURE.
REQ-022 In CAPTURE, ram_a SHALL hold its value and ram_re SHALL stay 1; s_data SHALL register ram_d at the end of the cycle and the next state SHALL be OUT.
REQ-023 In OUT, s_valid SHALL be 1, and s_data SHALL remain stable until the handshake completes.
REQ-024 When the OUT handshake occurs with remaining>1, remaining SHALL decrement, the address counter SHALL increment, and the next state SHALL be ISSUE.
REQ-025 When the OUT handshake occurs with remaining=1, the next state SHALL be FIN.
REQ-026 In FIN, done SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-027 The address counter SHALL wrap modulo 2**ADDR_BUS_WIDTH, so the address after all-ones is zero.
REQ-028 ram_re SHALL be 0, and ram_a SHALL hold its last value, in IDLE, OUT and FIN.
REQ-029 s_valid SHALL be 0 in every state other than OUT.
REQ-030 Latency: from the start edge, the first s_valid SHALL be asserted 3 cycles later.
REQ-031 With s_ready held high, words SHALL be produced at one word per 3 cycles.
REQ-032 start SHALL be ignored in every state except IDLE.
REQ-033 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with no done pulse, s_valid=0 and ram_re=0.
REQ-034 abort SHALL take priority over both a handshake and start in the same cycle.
REQ-035 If abort and start are high in the same cycle while in IDLE, start SHALL be honoured.

Reset
REQ-036 On rst=1 at an edge, the block SHALL enter IDLE, and busy, done, s_valid and ram_re SHALL all be 0.
REQ-037 On reset, ram_a, s_data, the address counter and the remaining counter SHALL all be zero.
REQ-038 Reset SHALL override abort, start and an in-progress transfer.
REQ-039 No done pulse SHALL follow a reset.

Verification
REQ-040 Basic read: RAM preloaded with mem[0x10..0x12]=A1,B2,C3; start, base=0x10, len=3, s_ready=1. Required: s_data sequence A1,B2,C3; first s_valid 3 cycles after start; one done pulse; busy is low the cycle after done.
REQ-041 Backpressure: s_ready low for 5 cycles during the second word. Required: s_data stays stable, ram_re stays 0 while stalled, and no word is lost or duplicated.
REQ-042 Wrap: base=0x1FFF, len=2, with mem[0x1FFF]=5A and mem[0]=6B. Required: ram_a sequence 0x1FFF then 0x0000; output 5A,6B.
REQ-043 Zero length: start with len=0. Required: done pulses 1 cycle later, ram_re is never asserted, and s_valid is never asserted.
REQ-044 Abort and restart: abort in CAPTURE of word 2 of a len=4 transfer. Required: IDLE next cycle with no done; a following start (base=0x20, len=1) completes normally.
REQ-045 Reset mid-transfer: rst in OUT with s_valid high. Required: all outputs match REQ-036 and REQ-037 next cycle; start issued while busy is ignored.
